ubbks_pipe_17: RTL and testbench

- Pipelined unsigned Brent-Kung subtractor: the inverse operation of the 17-bit unsigned BK adder.
- Takes an 18-bit sum S and a 17-bit operand X and recovers the other operand, D = S - X.
- Flags borrow and out-of-range results.
- Sits downstream of the adder datapath in check and recovery paths. Valid/ready handshake on both sides; 3 register stages built from the GP-generate / carry-operator prefix structure.

---
 rtl/ubbks_pipe_17.sv | 130 +++++++++++++
 tb/tb_ubbks_pipe_17.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ubbks_pipe_17.sv
// ubbks_pipe_17: three-stage pipelined Brent-Kung subtractor.
// Recovers D = S - X from an 18-bit adder sum S and a 17-bit operand X.
// Flags BORROW when S < X and WIDE when a non-negative D needs 18 bits.
//
// Handshake: a beat moves across an interface on a rising edge where
// valid and ready are both 1. While valid is 1 and ready is 0, the payload
// is held. IN_READY depends combinationally only on OUT_READY and the
// stage valid bits. It never depends on IN_VALID.
module ubbks_pipe_17 #(
    parameter int XW     = 17,
    parameter int STAGES = 3
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [XW:0]   S,
    input  logic [XW-1:0] X,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [XW:0]   D,
    output logic          BORROW,
    output logic          WIDE
);
    localparam int N  = XW + 1;
    localparam int LV = $clog2(N);

    // Stage valid bits: vld[0] = stage 1, vld[1] = stage 2, vld[2] = stage 3.
    logic [STAGES-1:0] vld;
    logic              ld1, ld2, ld3;

    // Stage 1 payload.
    logic [N-1:0]  s1_s;
    logic [XW-1:0] s1_x;

    // Stage 2 payload: prefix G/P after up-sweep, plus bitwise propagate for the sum.
    logic [N-1:0] s2_g, s2_p, s2_p0;

    // Stage 3 payload.
    logic [N-1:0] s3_d;
    logic         s3_borrow, s3_wide;

    // Combinational stage logic.
    logic [N-1:0] nx, g0, p0, gu, pu;
    logic [N-1:0] gd, pd, carry, sum;
    logic         cout;

    // Stage k can take a new beat when it is empty or when its content moves on.
    always_comb begin
        ld3      = ~vld[2] | OUT_READY;
        ld2      = ~vld[1] | ld3;
        ld1      = ~vld[0] | ld2;
        IN_READY = ld1;
    end

    // Valid bits. These are the only reset state, so bubbles collapse as beats advance.
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld <= '0;
        end else begin
            if (ld1) vld[0] <= IN_VALID;
            if (ld2) vld[1] <= vld[0];
            if (ld3) vld[2] <= vld[1];
        end
    end

    // Generate/propagate over S and ~X, followed by the BK up-sweep (levels 1..LV).
    always_comb begin
        nx = ~{1'b0, s1_x};
        g0 = s1_s & nx;
        p0 = s1_s ^ nx;
        gu = g0;
        pu = p0;
        for (int l = 1; l <= LV; l++) begin
            for (int i = 0; i < N; i++) begin
                if (((i + 1) % (1 << l)) == 0) begin
                    gu[i] = gu[i] | (pu[i] & gu[i - (1 << (l - 1))]);
                    pu[i] = pu[i] & pu[i - (1 << (l - 1))];
                end
            end
        end
    end

    // BK down-sweep. The carry-in of 1 is folded in as carry = G | P of each prefix group.
    always_comb begin
        gd = s2_g;
        pd = s2_p;
        for (int l = LV - 1; l >= 1; l--) begin
            for (int i = 0; i < N; i++) begin
                if ((((i + 1) % (1 << l)) == (1 << (l - 1))) && (i >= (1 << l))) begin
                    gd[i] = gd[i] | (pd[i] & gd[i - (1 << (l - 1))]);
                    pd[i] = pd[i] & pd[i - (1 << (l - 1))];
                end
            end
        end
        for (int i = 1; i < N; i++) begin
            gd[i] = gd[i] | (pd[i] & gd[i - 1]) ;
            pd[i] = pd[i] & pd[i - 1];
        end
        carry = {gd[N-2:0] | pd[N-2:0], 1'b1};
        sum   = s2_p0 ^ carry;
        cout  = gd[N-1] | pd[N-1];
    end

    // Pipeline payload registers. These are loaded only with valid beats and are never reset.
    always_ff @(posedge CLK) begin
        if (ld1 && IN_VALID) begin
            s1_s <= S;
            s1_x <= X;
        end
        if (ld2 && vld[0]) begin
            s2_g  <= gu;
            s2_p  <= pu;
            s2_p0 <= p0;
        end
        if (ld3 && vld[1]) begin
            s3_d      <= sum;
            s3_borrow <= ~cout;
            s3_wide   <= sum[N-1] & cout;
        end
    end

    // Output assignments.
    always_comb begin
        OUT_VALID = vld[2];
        D         = s3_d;
        BORROW    = s3_borrow;
        WIDE      = s3_wide;
    end
endmodule

// File: tb/tb_ubbks_pipe_17.sv
// tb_ubbks_pipe_17: scoreboard bench for the pipelined BK subtractor.
`timescale 1ns/1ps
module tb_ubbks_pipe_17;
  logic        CLK;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic [17:0] S;
  logic [16:0] X;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [17:0] D;
  logic        BORROW;
  logic        WIDE;

  int checks = 0;
  int failures = 0;
  int out_count = 0;
  logic [19:0] exp_q[$];
  logic [19:0] mon_exp;

  ubbks_pipe_17 #(.XW(17), .STAGES(3)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .S(S), .X(X), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .D(D), .BORROW(BORROW), .WIDE(WIDE)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // reference: {D, BORROW, WIDE}
  function automatic logic [19:0] model(input logic [17:0] s, input logic [16:0] x);
    logic [18:0] diff;
    logic        b;
    logic        w;
    diff = {1'b0, s} - {2'b00, x};
    b = (s < {1'b0, x});
    w = !b && (diff[17:0] > 18'h1FFFF);
    return {diff[17:0], b, w};
  endfunction

  // scoreboard: push on accept, pop on emit (sampled on falling edge)
  always @(negedge CLK) begin
    if (RST === 1'b1) begin
      exp_q.delete();
    end else begin
      if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
        checks++;
        out_count++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected got D=%h B=%b W=%b with no beat pending", D, BORROW, WIDE);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({D, BORROW, WIDE} !== mon_exp) begin
            failures++;
            $display("FAIL sb_result got D=%h B=%b W=%b exp D=%h B=%b W=%b",
                     D, BORROW, WIDE, mon_exp[19:2], mon_exp[1], mon_exp[0]);
          end
        end
      end
      if (IN_VALID === 1'b1 && IN_READY === 1'b1) exp_q.push_back(model(S, X));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [17:0] s, input logic [16:0] x);
    bit done;
    done = 0;
    IN_VALID = 1'b1;
    S = s;
    X = x;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge CLK);
      if (IN_READY === 1'b1) done = 1;
      tick();
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL send_timeout S=%h X=%h not accepted in 100 cycles", s, x);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; IN_VALID = 1'b0; S = '0; X = '0; OUT_READY = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
      failures++;
      $display("FAIL reset_state got OUT_VALID=%b IN_READY=%b exp 0 1", OUT_VALID, IN_READY);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      checks++;
      if (OUT_VALID !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle cycle %0d got OUT_VALID=%b exp 0", c, OUT_VALID);
      end
    end
    tick();
  endtask

  task automatic test_single();
    send(18'h1F000, 17'h0F000);
    IN_VALID = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge CLK);
      checks++;
      if (c < 3 && OUT_VALID !== 1'b0) begin
        failures++;
        $display("FAIL single_early cycle %0d got OUT_VALID=%b exp 0", c, OUT_VALID);
      end
      if (c == 3 && (OUT_VALID !== 1'b1 || {D, BORROW, WIDE} !== {18'h10000, 2'b00})) begin
        failures++;
        $display("FAIL single_latency got V=%b D=%h B=%b W=%b exp V=1 D=10000 B=0 W=0",
                 OUT_VALID, D, BORROW, WIDE);
      end
    end
    tick();
  endtask

  task automatic test_boundaries();
    logic [17:0] bs[3];
    logic [16:0] bx[3];
    logic [19:0] be[3];
    bit got;
    bs[0] = 18'h00000; bx[0] = 17'h1FFFF; be[0] = {18'h20001, 2'b10};
    bs[1] = 18'h3FFFF; bx[1] = 17'h00000; be[1] = {18'h3FFFF, 2'b01};
    bs[2] = 18'h12345; bx[2] = 17'h12345; be[2] = {18'h00000, 2'b00};
    for (int k = 0; k < 3; k++) begin
      send(bs[k], bx[k]);
      IN_VALID = 1'b0;
      got = 0;
      for (int n = 0; n < 20 && !got; n++) begin
        @(negedge CLK);
        if (OUT_VALID === 1'b1) got = 1;
      end
      checks++;
      if (!got || {D, BORROW, WIDE} !== be[k]) begin
        failures++;
        $display("FAIL boundary_%0d got V=%b D=%h B=%b W=%b exp D=%h B=%b W=%b",
                 k, OUT_VALID, D, BORROW, WIDE, be[k][19:2], be[k][1], be[k][0]);
      end
      tick();
    end
  endtask

  task automatic test_round_trip();
    int base;
    int stalls;
    logic [16:0] a;
    logic [16:0] b;
    base = out_count;
    stalls = 0;
    OUT_READY = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      a = 17'($urandom_range(0, 17'h1FFFF));
      b = 17'($urandom_range(0, 17'h1FFFF));
      S = {1'b0, a} + {1'b0, b};
      X = a;
      IN_VALID = 1'b1;
      @(negedge CLK);
      if (IN_READY !== 1'b1) stalls++;
      tick();
    end
    IN_VALID = 1'b0;
    checks++;
    if (stalls != 0) begin
      failures++;
      $display("FAIL round_trip_ready got %0d stall cycles exp 0", stalls);
    end
    repeat (4) tick();
    @(negedge CLK);
    checks++;
    if (out_count - base != 1000) begin
      failures++;
      $display("FAIL round_trip_count got %0d results exp 1000", out_count - base);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [17:0] ps[6];
    logic [16:0] px[6];
    logic [19:0] held;
    logic [19:0] first_exp;
    int base;
    for (int k = 0; k < 6; k++) begin
      ps[k] = 18'($urandom_range(0, 18'h3FFFF));
      px[k] = 17'($urandom_range(0, 17'h1FFFF));
    end
    first_exp = model(ps[0], px[0]);
    base = out_count;
    OUT_READY = 1'b0;
    fork
      begin
        for (int k = 0; k < 6; k++) send(ps[k], px[k]);
        IN_VALID = 1'b0;
      end
      begin
        for (int c = 1; c <= 5; c++) begin
          @(negedge CLK);
          if (c == 4) begin
            held = {D, BORROW, WIDE};
            checks++;
            if (OUT_VALID !== 1'b1 || IN_READY !== 1'b0 || held !== first_exp) begin
              failures++;
              $display("FAIL bp_full got V=%b RDY=%b D=%h exp V=1 RDY=0 D=%h",
                       OUT_VALID, IN_READY, D, first_exp[19:2]);
            end
          end
          if (c == 5) begin
            checks++;
            if (OUT_VALID !== 1'b1 || IN_READY !== 1'b0 || {D, BORROW, WIDE} !== held) begin
              failures++;
              $display("FAIL bp_hold got V=%b RDY=%b D=%h exp V=1 RDY=0 D=%h",
                       OUT_VALID, IN_READY, D, held[19:2]);
            end
          end
        end
        tick();
        OUT_READY = 1'b1;
      end
    join
    repeat (6) tick();
    @(negedge CLK);
    checks++;
    if (out_count - base != 6 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL bp_drain got %0d results, %0d pending exp 6, 0", out_count - base, exp_q.size());
    end
    tick();
  endtask

  task automatic test_reset_midstream();
    bit got;
    OUT_READY = 1'b0;
    send(18'h2ABCD, 17'h01234);
    send(18'h11111, 17'h00FFF);
    IN_VALID = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
      failures++;
      $display("FAIL midreset_state got OUT_VALID=%b IN_READY=%b exp 0 1", OUT_VALID, IN_READY);
    end
    tick();
    OUT_READY = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      checks++;
      if (OUT_VALID !== 1'b0) begin
        failures++;
        $display("FAIL midreset_stale cycle %0d got OUT_VALID=%b D=%h exp 0", c, OUT_VALID, D);
      end
    end
    tick();
    send(18'd5, 17'd3);
    IN_VALID = 1'b0;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge CLK);
      if (OUT_VALID === 1'b1) got = 1;
    end
    checks++;
    if (!got || {D, BORROW, WIDE} !== {18'd2, 2'b00}) begin
      failures++;
      $display("FAIL midreset_new got V=%b D=%h B=%b W=%b exp V=1 D=2 B=0 W=0",
               OUT_VALID, D, BORROW, WIDE);
    end
    tick();
  endtask

  // main sequence and report
  initial begin
    test_reset();
    test_single();
    test_boundaries();
    test_round_trip();
    test_backpressure();
    test_reset_midstream();
    repeat (5) tick();
    @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL final_drain got %0d pending results exp 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // time limit
  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
